platform_nios_cpu_ocimem_ctrl: RTL and testbench

//  - Consumes the debug-slave sysclk outputs (jdo, take_*_ocimem_* strobes) and executes JTAG reads/writes into the on-chip debug RAM.
//  - Returns the read word on MonDReg to the debug-slave TCK stage.
//  - Also exposes the same RAM to the CPU via an Avalon-MM slave. JTAG has priority; CPU accesses stall via waitrequest.

---
 rtl/platform_nios_cpu_ocimem_ctrl_if.sv | 23 ++
 rtl/platform_nios_cpu_ocimem_ctrl.sv | 152 +++++++++++++++
 tb/tb_platform_nios_cpu_ocimem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/platform_nios_cpu_ocimem_ctrl_if.sv
// Avalon-MM slave bus giving the CPU access to the on-chip debug RAM.
interface platform_nios_cpu_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_debugaccess;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/platform_nios_cpu_ocimem_ctrl.sv
// Debug RAM shared by JTAG (ocimem strobes, priority) and CPU Avalon slave; PLATFORM_OCIMEM_WRITE_PROTECT_EN guards top-quarter ROM.
// Latency: JTAG read strobe -> MonDReg after 3 cycles; CPU write 0 wait states; CPU read 1 wait state when uncontended.
// Backpressure: CPU stalled via avs_waitrequest while a JTAG op is pending/in flight; strobes are never stalled (1-deep, overwrite).
module platform_nios_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [37:0]                    jdo,
  input  logic                           take_action_ocimem_a,
  input  logic                           take_action_ocimem_b,
  input  logic                           take_no_action_ocimem_a,
  platform_nios_cpu_ocimem_ctrl_if.slave avs,
  output logic [DATA_W-1:0]              MonDReg,
  output logic [ADDR_W-1:0]              MonAReg,
  output logic                           jtag_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, JTAG_RD, CPU_RD} state_t;
  typedef enum logic [1:0] {OP_WR, OP_LD, OP_RD} op_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  state_t            state;
  logic              pend_vld;
  op_t               pend_op;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_autoread;
  logic [DATA_W-1:0] pend_wdata;

  logic              strobe_any;
  logic              pending;
  logic              jtag_go;
  logic              cpu_wr_go;
  logic              cpu_rd_go;
  logic              wr_allow;
  logic [3:0]        ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] mon_a_inc;

  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // A strobe arriving this cycle already holds off the CPU so JTAG keeps priority.
  assign pending    = pend_vld | strobe_any;
  assign jtag_go    = (state == IDLE) & pend_vld;
  assign cpu_wr_go  = (state == IDLE) & ~pending & avs.avs_write;
  assign cpu_rd_go  = (state == IDLE) & ~pending & avs.avs_read & ~avs.avs_write;
  assign mon_a_inc  = MonAReg + 1'b1;

`ifdef PLATFORM_OCIMEM_WRITE_PROTECT_EN
  assign wr_allow = ~(&avs.avs_address[ADDR_W-1:ADDR_W-2]) | avs.avs_debugaccess;
  logic unused_ok;
  assign unused_ok = ^{jdo[37:36], jdo[2:0]};
`else
  assign wr_allow = 1'b1;
  logic unused_ok;
  assign unused_ok = ^{jdo[37:36], jdo[2:0], avs.avs_debugaccess};
`endif

  always_comb begin
    ram_we    = 4'h0;
    ram_re    = 1'b0;
    ram_addr  = avs.avs_address;
    ram_wdata = avs.avs_writedata;
    if (jtag_go) begin
      ram_addr  = MonAReg;
      ram_wdata = pend_wdata;
      if (pend_op == OP_WR) ram_we = 4'hF;
      if (pend_op == OP_RD) ram_re = 1'b1;
    end else if (cpu_wr_go) begin
      ram_we = wr_allow ? avs.avs_byteenable : 4'h0;
    end else if (cpu_rd_go) begin
      ram_re = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else if (ram_re) rd_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pend_vld      <= 1'b0;
      pend_op       <= OP_LD;
      pend_addr     <= '0;
      pend_autoread <= 1'b0;
      pend_wdata    <= '0;
      MonDReg       <= '0;
      MonAReg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_vld) begin
            case (pend_op)
              OP_WR: begin
                MonAReg  <= mon_a_inc;
                pend_vld <= 1'b0;
              end
              OP_LD: begin
                MonAReg  <= pend_addr;
                pend_vld <= pend_autoread;
                pend_op  <= OP_RD;
              end
              default: begin
                // Read is now in flight; busy is carried by JTAG_RD so a strobe landing here is kept.
                pend_vld <= 1'b0;
                state    <= JTAG_RD;
              end
            endcase
          end else if (cpu_rd_go) begin
            state <= CPU_RD;
          end
        end
        JTAG_RD: begin
          MonDReg <= rd_q;
          MonAReg <= mon_a_inc;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (strobe_any) begin
        pend_vld      <= 1'b1;
        pend_addr     <= jdo[16+ADDR_W:17];
        pend_autoread <= jdo[35];
        pend_wdata    <= jdo[34:3];
        if (take_action_ocimem_b)      pend_op <= OP_WR;
        else if (take_action_ocimem_a) pend_op <= OP_LD;
        else                           pend_op <= OP_RD;
      end
    end
  end

  assign jtag_busy           = pending | (state == JTAG_RD);
  assign avs.avs_readdata    = rd_q;
  assign avs.avs_waitrequest = (avs.avs_read | avs.avs_write) &
                               ~(((state == IDLE) & ~pending & avs.avs_write) | (state == CPU_RD));

endmodule

// File: tb/tb_platform_nios_cpu_ocimem_ctrl.sv
// Randomized self-checking bench for the debug RAM controller against a word-array reference model.
module tb_platform_nios_cpu_ocimem_ctrl;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_a, take_b, take_na;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              jtag_busy;

  int tests = 0;
  int fails = 0;

  logic [31:0]       model_mem [DEPTH];
  logic [ADDR_W-1:0] exp_a;
  logic [31:0]       exp_d;

  platform_nios_cpu_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) avs ();

  platform_nios_cpu_ocimem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .avs                     (avs),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .jtag_busy               (jtag_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [37:0] rnd_jdo();
    return {6'($urandom), $urandom};
  endfunction

  function automatic bit cpu_write_blocked(input int addr, input bit dbg);
`ifdef PLATFORM_OCIMEM_WRITE_PROTECT_EN
    return (addr >= (DEPTH * 3) / 4) && !dbg;
`else
    return 1'b0;
`endif
  endfunction

  // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a
  task automatic strobe(input int kind, input logic [37:0] j);
    @(negedge clk);
    jdo = j; take_a = (kind == 0); take_b = (kind == 1); take_na = (kind == 2);
    @(negedge clk);
    take_a = 1'b0; take_b = 1'b0; take_na = 1'b0; jdo = rnd_jdo();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    #1;
    while (jtag_busy && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (jtag_busy) begin
      tests++; fails++;
      $display("FAIL %s: jtag_busy still high after %0d cycles", tag, n);
    end
  endtask

  task automatic jtag_load(input int addr, input bit ar);
    logic [37:0] j = rnd_jdo();
    j[35] = ar;
    j[16+ADDR_W:17] = ADDR_W'(addr);
    strobe(0, j);
    wait_idle("load");
    exp_a = ADDR_W'(addr);
    if (ar) begin
      exp_d = model_mem[exp_a];
      exp_a++;
    end
  endtask

  task automatic jtag_write(input logic [31:0] wd);
    logic [37:0] j = rnd_jdo();
    j[34:3] = wd;
    strobe(1, j);
    wait_idle("write");
    model_mem[exp_a] = wd;
    exp_a++;
  endtask

  task automatic jtag_read();
    strobe(2, rnd_jdo());
    wait_idle("read");
    exp_d = model_mem[exp_a];
    exp_a++;
  endtask

  task automatic cpu_access(input bit wr, input int addr, input logic [31:0] wd, input logic [3:0] be,
                            input bit dbg, output logic [31:0] rd, output int waits);
    bit done = 0;
    rd = '0; waits = 0;
    @(negedge clk);
    avs.avs_address = ADDR_W'(addr); avs.avs_writedata = wd; avs.avs_byteenable = be;
    avs.avs_debugaccess = dbg; avs.avs_write = wr; avs.avs_read = !wr;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!avs.avs_waitrequest) begin rd = avs.avs_readdata; done = 1; end
      @(negedge clk);
      if (done) break;
      waits++;
    end
    avs.avs_read = 1'b0; avs.avs_write = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL cpu_timeout: waitrequest never dropped (addr %0h)", addr);
    end else if (wr && !cpu_write_blocked(addr, dbg)) begin
      for (int b = 0; b < 4; b++) if (be[b]) model_mem[addr][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
    avs.avs_address = '0; avs.avs_read = 0; avs.avs_write = 0; avs.avs_writedata = '0;
    avs.avs_byteenable = '0; avs.avs_debugaccess = 0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL reset_mond: got %h want 0", MonDReg); end
    tests++; if (MonAReg !== 8'h0) begin fails++; $display("FAIL reset_mona: got %h want 0", MonAReg); end
    tests++; if (jtag_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", jtag_busy); end
    tests++; if (avs.avs_readdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", avs.avs_readdata); end
    tests++; if (avs.avs_waitrequest !== 1'b0) begin fails++; $display("FAIL reset_wait: got %b want 0", avs.avs_waitrequest); end
    @(negedge clk); reset_n = 1'b1;
    exp_a = '0; exp_d = '0;
  endtask

  task automatic test_fill();
    jtag_load(0, 0);
    for (int i = 0; i < DEPTH; i++) jtag_write($urandom);
    tests++; if (MonAReg !== exp_a || exp_a !== 8'h00) begin
      fails++; $display("FAIL fill_wrap: MonAReg %h want 00", MonAReg);
    end
  endtask

  task automatic test_load_write();
    jtag_load(16, 0);
    tests++; if (MonAReg !== 8'h10) begin fails++; $display("FAIL load_addr: MonAReg %h want 10", MonAReg); end
    jtag_write(32'hDEADBEEF);
    tests++; if (MonAReg !== 8'h11) begin fails++; $display("FAIL write_inc: MonAReg %h want 11", MonAReg); end
  endtask

  task automatic test_autoread();
    jtag_load(16, 1);
    tests++; if (MonDReg !== 32'hDEADBEEF) begin fails++; $display("FAIL autoread_data: MonDReg %h want deadbeef", MonDReg); end
    tests++; if (MonAReg !== 8'h11) begin fails++; $display("FAIL autoread_addr: MonAReg %h want 11", MonAReg); end
  endtask

  task automatic test_read_latency();
    logic [31:0] val = $urandom;
    logic [31:0] old;
    if (val == exp_d) val = ~val;
    jtag_load(48, 0);
    jtag_write(val);
    jtag_load(48, 0);
    old = exp_d;
    @(negedge clk); take_na = 1'b1;
    @(negedge clk); take_na = 1'b0;
    @(negedge clk); #1;
    tests++; if (MonDReg !== old) begin fails++; $display("FAIL lat_early: MonDReg %h want %h", MonDReg, old); end
    @(negedge clk); #1;
    tests++; if (MonDReg !== val) begin fails++; $display("FAIL lat_n3: MonDReg %h want %h", MonDReg, val); end
    wait_idle("latency");
    exp_d = val; exp_a = 8'h31;
    tests++; if (MonAReg !== exp_a) begin fails++; $display("FAIL lat_addr: MonAReg %h want %h", MonAReg, exp_a); end
  endtask

  task automatic test_wrap();
    jtag_load(255, 0);
    jtag_read();
    tests++; if (MonDReg !== model_mem[255]) begin fails++; $display("FAIL wrap_data: MonDReg %h want %h", MonDReg, model_mem[255]); end
    tests++; if (MonAReg !== 8'h00) begin fails++; $display("FAIL wrap_addr: MonAReg %h want 00", MonAReg); end
  endtask

  task automatic test_conflict();
    logic [31:0] nv;
    logic [31:0] rd = '0;
    logic [37:0] j = rnd_jdo();
    int waits = 0;
    bit done = 0;
    jtag_load(32, 0);
    nv = ~model_mem[32];
    j[34:3] = nv;
    @(negedge clk);
    jdo = j; take_b = 1'b1;
    avs.avs_address = 8'h20; avs.avs_read = 1'b1; avs.avs_byteenable = 4'hF;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!avs.avs_waitrequest) begin rd = avs.avs_readdata; done = 1; end
      @(negedge clk);
      take_b = 1'b0;
      if (done) break;
      waits++;
    end
    avs.avs_read = 1'b0;
    wait_idle("conflict");
    model_mem[32] = nv; exp_a = 8'h21;
    tests++; if (!done || rd !== nv) begin fails++; $display("FAIL conflict_data: readdata %h want %h (done %0d)", rd, nv, done); end
    tests++; if (waits < 2) begin fails++; $display("FAIL conflict_wait: %0d wait cycles want >=2", waits); end
    tests++; if (MonAReg !== 8'h21) begin fails++; $display("FAIL conflict_addr: MonAReg %h want 21", MonAReg); end
  endtask

  task automatic test_protect();
    logic [31:0] old = model_mem[192];
    logic [31:0] want, rd;
    int waits;
`ifdef PLATFORM_OCIMEM_WRITE_PROTECT_EN
    want = old;
`else
    want = 32'h12345678;
`endif
    cpu_access(1, 192, 32'h12345678, 4'hF, 0, rd, waits);
    tests++; if (waits != 0) begin fails++; $display("FAIL protect_wait: %0d wait cycles want 0", waits); end
    cpu_access(0, 192, '0, 4'hF, 0, rd, waits);
    tests++; if (rd !== want) begin fails++; $display("FAIL protect_data: readdata %h want %h", rd, want); end
    tests++; if (waits != 1) begin fails++; $display("FAIL cpu_rd_wait: %0d wait cycles want 1", waits); end
    cpu_access(1, 193, 32'hA5A55A5A, 4'hF, 1, rd, waits);
    cpu_access(0, 193, '0, 4'hF, 0, rd, waits);
    tests++; if (rd !== 32'hA5A55A5A) begin fails++; $display("FAIL dbg_write: readdata %h want a5a55a5a", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int waits, addr;
    for (int n = 0; n < 120; n++) begin
      addr = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 4))
        0: begin
          jtag_load(addr, 0);
          jtag_write($urandom);
          tests++; if (MonAReg !== exp_a) begin fails++; $display("FAIL rnd_jwr_addr: MonAReg %h want %h", MonAReg, exp_a); end
        end
        1: begin
          jtag_load(addr, 1);
          tests++; if (MonDReg !== exp_d || MonAReg !== exp_a) begin
            fails++; $display("FAIL rnd_autoread: MonDReg %h MonAReg %h want %h %h", MonDReg, MonAReg, exp_d, exp_a);
          end
        end
        2: begin
          jtag_read();
          tests++; if (MonDReg !== exp_d || MonAReg !== exp_a) begin
            fails++; $display("FAIL rnd_jrd: MonDReg %h MonAReg %h want %h %h", MonDReg, MonAReg, exp_d, exp_a);
          end
        end
        3: cpu_access(1, addr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rd, waits);
        default: begin
          cpu_access(0, addr, '0, 4'hF, 0, rd, waits);
          tests++; if (rd !== model_mem[addr]) begin fails++; $display("FAIL rnd_cpu_rd: addr %h readdata %h want %h", addr, rd, model_mem[addr]); end
        end
      endcase
    end
  endtask

  task automatic test_reset_midop();
    jtag_load(64, 0);
    @(negedge clk); take_na = 1'b1;
    @(negedge clk); take_na = 1'b0;
    @(negedge clk); #1;
    tests++; if (jtag_busy !== 1'b1) begin fails++; $display("FAIL midop_busy: got %b want 1", jtag_busy); end
    reset_n = 1'b0; #1;
    tests++; if (MonDReg !== 32'h0 || MonAReg !== 8'h0 || jtag_busy !== 1'b0) begin
      fails++; $display("FAIL midop_reset: MonDReg %h MonAReg %h busy %b want 0 0 0", MonDReg, MonAReg, jtag_busy);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk); #1;
    tests++; if (MonDReg !== 32'h0 || MonAReg !== 8'h0 || jtag_busy !== 1'b0) begin
      fails++; $display("FAIL midop_release: MonDReg %h MonAReg %h busy %b want 0 0 0", MonDReg, MonAReg, jtag_busy);
    end
    exp_a = '0; exp_d = '0;
    jtag_read();
    tests++; if (MonDReg !== model_mem[0]) begin fails++; $display("FAIL midop_ram: MonDReg %h want %h", MonDReg, model_mem[0]); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_write();
    test_autoread();
    test_read_latency();
    test_wrap();
    test_conflict();
    test_protect();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
